// File: rtl/sigmoid_pkg.sv
// Shared Q4.28 constants, function IDs, FSM state encoding and saturation helper
// for the sigmoid sequencer.
package sigmoid_pkg;

  localparam logic [31:0] ONE       = 32'h1000_0000;
  localparam logic [31:0] TWO       = 32'h2000_0000;
  localparam logic [31:0] INV2      = 32'h0800_0000;
  localparam logic [31:0] INV6      = 32'h02AA_AAAA;
  localparam logic [31:0] INV24     = 32'h00AA_AAAA;
  localparam logic [31:0] INV120    = 32'h0022_2222;
  localparam logic [31:0] C_48_17   = 32'h2D2D_2D2D;
  localparam logic [31:0] NEG_32_17 = 32'hE1E1_E1E2;

  localparam logic [31:0] X_MIN = 32'hE000_0000;
  localparam logic [31:0] X_MAX = 32'h1E00_0000;

  localparam logic [9:0] FID_SIGMOID_DEF = 10'd1;
  localparam logic [9:0] FID_PERF_READ   = 10'd2;
  localparam logic [9:0] FID_PERF_CLEAR  = 10'd3;

  typedef enum logic [2:0] {IDLE, EXP, ADD1, NORM, SEED, NR, OUT} state_t;

  function automatic logic [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (v < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
    return v[31:0];
  endfunction

endpackage

// File: rtl/sigmoid_seq_ctrl_mac.sv
// Combinational saturating Q4.28 multiply-add: r = sat32(((a*b) >>> 28) + c).
module q428_mac
  import sigmoid_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] r
);

  logic signed [63:0] a_ext, b_ext, c_ext, prod, sum;

  always_comb begin
    a_ext = {{32{a[31]}}, a};
    b_ext = {{32{b[31]}}, b};
    c_ext = {{32{c[31]}}, c};
    prod  = a_ext * b_ext;
    sum   = (prod >>> 28) + c_ext;
    r     = sat32(sum);
  end

endmodule

// File: rtl/sigmoid_seq_ctrl.sv
// Multi-cycle 1/(1+e^x) sequencer on one shared Q4.28 MAC behind a CFU cmd/rsp port.
// Optional SIGMOID_PERF_CNT_EN adds a completed-sigmoid counter (fid 2 read, fid 3 clear).
//
// state | meaning
// IDLE  | waiting for a command / holding a passthrough response
// EXP   | Horner steps of the 5th-order Taylor e^x (5 cycles)
// ADD1  | d = e^x + 1
// NORM  | shift d into [0.5,1), latch shift k
// SEED  | linear reciprocal seed 48/17 - 32/17*dn
// NR    | Newton-Raphson, alternating t and y updates
// OUT   | publish y >>> k
module sigmoid_seq_ctrl
  import sigmoid_pkg::*;
#(
  parameter int          NR_ITERS    = 3,
  parameter logic [9:0]  FID_SIGMOID = FID_SIGMOID_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        busy
);

  localparam logic [3:0] NR_LAST = 4'(2 * NR_ITERS - 1);

  state_t      state;
  logic [31:0] x_q, acc, dn, y, t;
  logic [1:0]  k;
  logic [3:0]  cnt;

  logic [31:0] mac_a, mac_b, mac_c, mac_r;
  logic [31:0] x_clamp, dn_norm, pt_data;
  logic [1:0]  k_norm;
  logic        accept;
  logic        unused_inputs;

  assign unused_inputs = ^cmd_payload_inputs_1;
  assign cmd_ready     = (state == IDLE) && !rsp_valid && !reset;
  assign accept        = cmd_valid && cmd_ready;

  always_comb begin
    if ($signed(cmd_payload_inputs_0) < $signed(X_MIN))      x_clamp = X_MIN;
    else if ($signed(cmd_payload_inputs_0) > $signed(X_MAX)) x_clamp = X_MAX;
    else                                                     x_clamp = cmd_payload_inputs_0;
  end

  // d is positive here, so logical shifts are safe; k saturates at 3.
  always_comb begin
    k_norm = 2'd3;
    if ((acc >> 2) < ONE) k_norm = 2'd2;
    if ((acc >> 1) < ONE) k_norm = 2'd1;
    dn_norm = acc >> k_norm;
  end

  always_comb begin
    mac_a = '0;
    mac_b = '0;
    mac_c = '0;
    case (state)
      EXP: begin
        mac_a = acc;
        mac_b = x_q;
        case (cnt)
          4'd4:    mac_c = INV24;
          4'd3:    mac_c = INV6;
          4'd2:    mac_c = INV2;
          default: mac_c = ONE;
        endcase
      end
      ADD1: begin
        mac_a = acc;
        mac_b = ONE;
        mac_c = ONE;
      end
      SEED: begin
        mac_a = dn;
        mac_b = NEG_32_17;
        mac_c = C_48_17;
      end
      NR: begin
        if (cnt[0]) begin
          mac_a = dn;
          mac_b = -y;
          mac_c = TWO;
        end else begin
          mac_a = y;
          mac_b = t;
        end
      end
      default: ;
    endcase
  end

  q428_mac u_mac (
    .a (mac_a),
    .b (mac_b),
    .c (mac_c),
    .r (mac_r)
  );

`ifdef SIGMOID_PERF_CNT_EN
  logic [31:0] perf_cnt;
  logic        rsp_sig;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_cnt <= '0;
      rsp_sig  <= 1'b0;
    end else begin
      if (state == OUT) rsp_sig <= 1'b1;
      else if (accept)  rsp_sig <= 1'b0;
      if (accept && cmd_payload_function_id == FID_PERF_CLEAR) perf_cnt <= '0;
      else if (rsp_valid && rsp_ready && rsp_sig)            perf_cnt <= perf_cnt + 32'd1;
    end
  end

  always_comb begin
    case (cmd_payload_function_id)
      FID_PERF_READ:  pt_data = perf_cnt;
      FID_PERF_CLEAR: pt_data = '0;
      default:        pt_data = cmd_payload_inputs_0;
    endcase
  end
`else
  assign pt_data = cmd_payload_inputs_0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= IDLE;
      rsp_valid             <= 1'b0;
      rsp_payload_outputs_0 <= '0;
      busy                  <= 1'b0;
      x_q                   <= '0;
      acc                   <= '0;
      dn                    <= '0;
      y                     <= '0;
      t                     <= '0;
      k                     <= '0;
      cnt                   <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cmd_payload_function_id == FID_SIGMOID) begin
              x_q   <= x_clamp;
              acc   <= INV120;
              cnt   <= 4'd4;
              busy  <= 1'b1;
              state <= EXP;
            end else begin
              rsp_valid             <= 1'b1;
              rsp_payload_outputs_0 <= pt_data;
            end
          end
        end
        EXP: begin
          acc <= mac_r;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= ADD1;
        end
        ADD1: begin
          acc   <= mac_r;
          state <= NORM;
        end
        NORM: begin
          dn    <= dn_norm;
          k     <= k_norm;
          state <= SEED;
        end
        SEED: begin
          y     <= mac_r;
          cnt   <= NR_LAST;
          state <= NR;
        end
        NR: begin
          if (cnt[0]) t <= mac_r;
          else        y <= mac_r;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= OUT;
        end
        OUT: begin
          rsp_payload_outputs_0 <= $signed(y) >>> k;
          rsp_valid             <= 1'b1;
          busy                  <= 1'b0;
          state                 <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_seq_ctrl.sv
// Self-checking bench for sigmoid_seq_ctrl: directed cases plus randomized ops
// compared against a fixed-point arithmetic reference of the sigmoid recipe.
module tb_sigmoid_seq_ctrl;

  localparam int          NR_ITERS = 3;
  localparam logic [9:0]  FID_SIG  = 10'd1;

  localparam logic [31:0] Q_ONE  = 32'h1000_0000;
  localparam logic [31:0] Q_TWO  = 32'h2000_0000;
  localparam logic [31:0] Q_I2   = 32'h0800_0000;
  localparam logic [31:0] Q_I6   = 32'h02AA_AAAA;
  localparam logic [31:0] Q_I24  = 32'h00AA_AAAA;
  localparam logic [31:0] Q_I120 = 32'h0022_2222;
  localparam logic [31:0] Q_C48  = 32'h2D2D_2D2D;
  localparam logic [31:0] Q_N32  = 32'hE1E1_E1E2;
  localparam logic [31:0] Q_XMIN = 32'hE000_0000;
  localparam logic [31:0] Q_XMAX = 32'h1E00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int sig_done = 0;

  sigmoid_seq_ctrl #(.NR_ITERS(NR_ITERS), .FID_SIGMOID(FID_SIG)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mac_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    longint p, s;
    p = longint'($signed(a)) * longint'($signed(b));
    s = (p >>> 28) + longint'($signed(c));
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return s[31:0];
  endfunction

  function automatic logic [31:0] sigmoid_ref(input logic [31:0] x);
    logic [31:0] coef [5] = '{Q_I24, Q_I6, Q_I2, Q_ONE, Q_ONE};
    logic [31:0] xc, e, d, dn, y, t;
    int k;
    if ($signed(x) < $signed(Q_XMIN))      xc = Q_XMIN;
    else if ($signed(x) > $signed(Q_XMAX)) xc = Q_XMAX;
    else                                   xc = x;
    e = Q_I120;
    foreach (coef[i]) e = mac_ref(e, xc, coef[i]);
    d = mac_ref(e, Q_ONE, Q_ONE);
    k = 3;
    for (int j = 3; j >= 1; j--) if ((d >> j) < Q_ONE) k = j;
    dn = d >> k;
    y = mac_ref(dn, Q_N32, Q_C48);
    for (int i = 0; i < NR_ITERS; i++) begin
      t = mac_ref(dn, -y, Q_TWO);
      y = mac_ref(y, t, 32'd0);
    end
    return 32'($signed(y) >>> k);
  endfunction

  function automatic logic [31:0] passthrough_ref(input logic [9:0] fid, input logic [31:0] in0);
`ifdef SIGMOID_PERF_CNT_EN
    if (fid == 10'd2) return 32'(sig_done);
    if (fid == 10'd3) return 32'd0;
`endif
    return in0;
  endfunction

  // Issue one command, hold the response for 'hold' cycles, then hand it off.
  task automatic run_op(input string tag, input logic [9:0] fid, input logic [31:0] in0,
                        input int hold, output logic [31:0] res);
    int n, lat, busy_drop, unstable;
    logic [31:0] exp_res;
    bit is_sig;
    is_sig  = (fid == FID_SIG);
    exp_res = is_sig ? sigmoid_ref(in0) : passthrough_ref(fid, in0);
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = $urandom;
    cmd_valid               = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) check({tag, "_ready_wait"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
`ifdef SIGMOID_PERF_CNT_EN
    if (fid == 10'd3) sig_done = 0;
`endif
    cmd_valid = 1'b0;
    lat = 0;
    busy_drop = 0;
    while (!rsp_valid && lat < 100) begin
      if (!busy) busy_drop++;
      cmd_valid               = 1'($urandom_range(0, 1));
      cmd_payload_function_id = 10'd5;
      cmd_payload_inputs_0    = $urandom;
      @(posedge clk); #1; lat++;
    end
    cmd_valid = 1'b0;
    // passthrough responds on the accept edge itself; sigmoid 9+2N edges later
    check({tag, "_lat"}, 32'(lat), is_sig ? 32'(9 + 2 * NR_ITERS) : 32'd0);
    if (is_sig) check({tag, "_busy_hi"}, 32'(busy_drop), 32'd0);
    check({tag, "_busy_lo"}, 32'(busy), 32'd0);
    check({tag, "_res"}, rsp_payload_outputs_0, exp_res);
    res = rsp_payload_outputs_0;
    unstable = 0;
    repeat (hold) begin
      cmd_valid               = 1'($urandom_range(0, 1));
      cmd_payload_function_id = 10'd5;
      @(posedge clk); #1;
      if (rsp_payload_outputs_0 !== res || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) unstable++;
    end
    if (hold > 0) check({tag, "_hold"}, 32'(unstable), 32'd0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    if (is_sig) sig_done++;
    check({tag, "_rsp_clr"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rdy_after"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] x;
    logic [9:0]  fid;
    int diff, n;

    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0 = '0;
    cmd_payload_inputs_1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_payload", rsp_payload_outputs_0, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    run_op("x0", FID_SIG, 32'h0000_0000, 0, res);
    diff = $signed(res) - 32'sh0800_0000;
    check("x0_near_half", 32'((diff <= 16) && (diff >= -16)), 32'd1);

    run_op("xmin", FID_SIG, 32'hE000_0000, 2, res);
    run_op("xclamp", FID_SIG, 32'h3000_0000, 20, res);
    check("xclamp_hi16", {16'd0, res[31:16]}, 32'h0000_0226);

    run_op("pt5", 10'd5, 32'hDEAD_BEEF, 1, res);

`ifdef SIGMOID_PERF_CNT_EN
    run_op("clr0", 10'd3, 32'h1234_5678, 0, res);
    repeat (3) run_op("cnt_sig", FID_SIG, $urandom, 0, res);
    run_op("rd3", 10'd2, 32'h1234_5678, 0, res);
    run_op("clr", 10'd3, 32'h1234_5678, 0, res);
    run_op("rd0", 10'd2, 32'h1234_5678, 0, res);
`else
    run_op("pt2", 10'd2, 32'h1234_5678, 0, res);
    run_op("pt3", 10'd3, 32'h8765_4321, 0, res);
`endif

    // abort a sigmoid part-way through with reset
    cmd_payload_function_id = FID_SIG;
    cmd_payload_inputs_0    = 32'h0400_0000;
    cmd_valid               = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_payload", rsp_payload_outputs_0, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    sig_done = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_abort_ready", 32'(cmd_ready), 32'd1);
    n = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (rsp_valid) n++;
    end
    check("no_stale_rsp", 32'(n), 32'd0);
    run_op("post_abort", FID_SIG, 32'hF800_0000, 0, res);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        fid = FID_SIG;
        if ($urandom_range(0, 1) == 1) x = $urandom;
        else x = 32'($signed(Q_XMIN) + $signed(32'($urandom_range(0, 32'h3E00_0000))));
      end else begin
        fid = 10'($urandom_range(4, 1023));
        x   = $urandom;
      end
      run_op("rand", fid, x, $urandom_range(0, 3), res);
    end

`ifdef SIGMOID_PERF_CNT_EN
    run_op("rd_final", 10'd2, 32'h0, 0, res);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
